// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl: controller for a direct-mapped, write-back data cache with
// 16 sets of 256-bit lines. A hit in IDLE completes in the same cycle. A miss
// walks MISS -> (WRITEBACK) -> READMISS -> READMISSOK -> IDLE. The CPU holds
// its request stable while stalled, and the request then replays as a hit.
//
// Optional feature: define DCACHE_CTRL_PERF_EN to add the hit/miss counters.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   cpu_req_i/we_i         CPU request strobe and write enable
//   cpu_addr_i/data_i      byte address and write word
//   cpu_data_o/stall_o     read word and stall
//   sram_addr_o            set index (always cpu_addr_i[8:5])
//   sram_tag_o/data_o      tag {valid, dirty, tag[22:0]} and line to write
//   sram_enable_o/write_o  SRAM access strobe and write enable
//   sram_tag_i/data_i      stored tag and line of the indexed set
//   sram_hit_i             stored line is valid and its tag matches
//   mem_enable_o/write_o   memory request and direction
//   mem_addr_o/data_o      line address and writeback data
//   mem_data_i/ack_i       refill data and one-cycle completion pulse
//   hit_cnt_o/miss_cnt_o   (DCACHE_CTRL_PERF_EN only) event counters
// ---------------------------------------------------------------------------
module dcache_ctrl (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         cpu_req_i,
   input  logic         cpu_we_i,
   input  logic [31:0]  cpu_addr_i,
   input  logic [31:0]  cpu_data_i,
   output logic [31:0]  cpu_data_o,
   output logic         cpu_stall_o,
   output logic [3:0]   sram_addr_o,
   output logic [24:0]  sram_tag_o,
   output logic [255:0] sram_data_o,
   output logic         sram_enable_o,
   output logic         sram_write_o,
   input  logic [24:0]  sram_tag_i,
   input  logic [255:0] sram_data_i,
   input  logic         sram_hit_i,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   input  logic [255:0] mem_data_i,
   input  logic         mem_ack_i
`ifdef DCACHE_CTRL_PERF_EN
  ,output logic [31:0]  hit_cnt_o,
   output logic [31:0]  miss_cnt_o
`endif
);

   localparam logic [2:0] StIdle       = 3'd0;
   localparam logic [2:0] StMiss       = 3'd1;
   localparam logic [2:0] StWriteback  = 3'd2;
   localparam logic [2:0] StReadMiss   = 3'd3;
   localparam logic [2:0] StReadMissOk = 3'd4;

   logic [2:0]   state_q, state_d;
   logic [22:0]  victim_tag_q, victim_tag_d;
   logic [255:0] victim_data_q, victim_data_d;
   logic [255:0] refill_q, refill_d;

   logic [22:0]  req_tag;
   logic [3:0]   req_index;
   logic [7:0]   word_lsb;
   logic         idle_hit;
   logic [255:0] merged_line;

   assign req_tag     = cpu_addr_i[31:9];
   assign req_index   = cpu_addr_i[8:5];
   assign word_lsb    = {cpu_addr_i[4:2], 5'b0};
   assign sram_addr_o = req_index;
   assign idle_hit    = (state_q == StIdle) & cpu_req_i & sram_hit_i;

   always_comb begin
      merged_line = sram_data_i;
      merged_line[word_lsb +: 32] = cpu_data_i;
   end

   assign cpu_data_o = idle_hit ? sram_data_i[word_lsb +: 32] : 32'h0;

   always_comb begin
      state_d       = state_q;
      victim_tag_d  = victim_tag_q;
      victim_data_d = victim_data_q;
      refill_d      = refill_q;
      cpu_stall_o   = 1'b1;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      sram_tag_o    = 25'h0;
      sram_data_o   = 256'h0;
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;
      mem_addr_o    = 32'h0;
      mem_data_o    = 256'h0;
      case (state_q)
         StIdle: begin
            cpu_stall_o = cpu_req_i & ~sram_hit_i;
            if (cpu_req_i) begin
               sram_enable_o = 1'b1;
               if (!sram_hit_i) begin
                  state_d = StMiss;
               end else if (cpu_we_i) begin
                  sram_write_o = 1'b1;
                  sram_tag_o   = {2'b11, req_tag};
                  sram_data_o  = merged_line;
               end
            end
         end
         StMiss: begin
            // SRAM is presenting the victim line of the indexed set.
            sram_enable_o = 1'b1;
            victim_tag_d  = sram_tag_i[22:0];
            victim_data_d = sram_data_i;
            state_d = (sram_tag_i[24] & sram_tag_i[23]) ? StWriteback : StReadMiss;
         end
         StWriteback: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {victim_tag_q, req_index, 5'b0};
            mem_data_o   = victim_data_q;
            if (mem_ack_i) state_d = StReadMiss;
         end
         StReadMiss: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {cpu_addr_i[31:5], 5'b0};
            if (mem_ack_i) begin
               refill_d = mem_data_i;
               state_d  = StReadMissOk;
            end
         end
         StReadMissOk: begin
            sram_enable_o = 1'b1;
            sram_write_o  = 1'b1;
            sram_tag_o    = {2'b10, req_tag};
            sram_data_o   = refill_q;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         victim_tag_q  <= 23'h0;
         victim_data_q <= 256'h0;
         refill_q      <= 256'h0;
      end else begin
         state_q       <= state_d;
         victim_tag_q  <= victim_tag_d;
         victim_data_q <= victim_data_d;
         refill_q      <= refill_d;
      end
   end

`ifdef DCACHE_CTRL_PERF_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   // Marks the IDLE cycle right after a refill, where the stalled request
   // replays as a hit that must not be counted.
   logic        replay_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_q  <= 32'h0;
         miss_cnt_q <= 32'h0;
         replay_q   <= 1'b0;
      end else begin
         replay_q <= (state_q == StReadMissOk);
         if (idle_hit && !replay_q) hit_cnt_q <= hit_cnt_q + 32'd1;
         if ((state_q == StIdle) && cpu_req_i && !sram_hit_i) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl. The bench plays the tag/data SRAM and the backing
// memory itself, and checks CPU-visible results against a flat word-memory
// model: a cache is transparent, so every read must return the last word
// written to that address, or the memory's initial contents.
module tb_dcache_ctrl;

   logic         clk = 1'b0;
   logic         rst_i, cpu_req_i, cpu_we_i;
   logic [31:0]  cpu_addr_i, cpu_data_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic [3:0]   sram_addr_o;
   logic [24:0]  sram_tag_o;
   logic [255:0] sram_data_o;
   logic         sram_enable_o, sram_write_o;
   logic [24:0]  sram_tag_i;
   logic [255:0] sram_data_i;
   logic         sram_hit_i;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
`ifdef DCACHE_CTRL_PERF_EN
   logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

   dcache_ctrl dut (
      .clk_i(clk), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
      .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
      .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
      .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_CTRL_PERF_EN
     ,.hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   // SRAM contents, written only by the stimulus process.
   logic [24:0]  s_tag  [16];
   logic [255:0] s_data [16];
   assign sram_tag_i  = s_tag[cpu_addr_i[8:5]];
   assign sram_data_i = s_data[cpu_addr_i[8:5]];
   assign sram_hit_i  = s_tag[cpu_addr_i[8:5]][24] &&
                        (s_tag[cpu_addr_i[8:5]][22:0] == cpu_addr_i[31:9]);

   logic [255:0] mem_line [int unsigned];
   logic [31:0]  shadow   [int unsigned];

   int errors = 0;
   int checks = 0;
   int hits_exp = 0;
   int misses_exp = 0;
   int mem_lat = 2;
   int mem_cnt = 0;
   bit mem_auto = 1'b1;

   logic         w_pend, ack_next;
   logic [3:0]   w_idx;
   logic [24:0]  w_tag;
   logic [255:0] w_data, mdata_next;

   function automatic logic [31:0] init_word(input int unsigned wa);
      return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [255:0] line_get(input logic [31:0] addr);
      logic [255:0] l;
      int unsigned la = addr >> 5;
      if (mem_line.exists(la)) return mem_line[la];
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word((la << 3) + i);
      return l;
   endfunction

   function automatic logic [31:0] shadow_get(input logic [31:0] addr);
      int unsigned wa = addr >> 2;
      return shadow.exists(wa) ? shadow[wa] : init_word(wa);
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [3:0] idx, input logic [22:0] tag, input logic dirty,
                          input logic [255:0] data);
      int unsigned la = {tag, idx};
      s_tag[idx]  = {1'b1, dirty, tag};
      s_data[idx] = data;
      for (int i = 0; i < 8; i++) shadow[(la << 3) + i] = data[i*32 +: 32];
      if (!dirty) mem_line[la] = data;
   endtask

   // Sample side: capture this cycle's SRAM write and run the memory responder.
   task automatic at_neg();
      @(negedge clk);
      w_pend = sram_enable_o && sram_write_o;
      w_idx  = sram_addr_o;
      w_tag  = sram_tag_o;
      w_data = sram_data_o;
      ack_next   = 1'b0;
      mdata_next = mem_data_i;
      if (mem_auto) begin
         if (mem_ack_i && mem_enable_o && mem_write_o) mem_line[mem_addr_o >> 5] = mem_data_o;
         if (mem_enable_o && !mem_ack_i) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
               ack_next   = 1'b1;
               mdata_next = line_get(mem_addr_o);
               mem_cnt    = 0;
            end
         end else begin
            mem_cnt = 0;
         end
      end
   endtask

   task automatic at_pos();
      @(posedge clk);
      #1;
      if (w_pend === 1'b1) begin
         s_tag[w_idx]  = w_tag;
         s_data[w_idx] = w_data;
      end
      if (mem_auto) begin
         mem_ack_i  = ack_next;
         mem_data_i = mdata_next;
      end
   endtask

   function automatic logic cond(input int sel);
      case (sel)
         0:       return mem_enable_o && !mem_write_o;
         1:       return mem_enable_o && mem_write_o;
         2:       return sram_write_o;
         default: return !cpu_stall_o;
      endcase
   endfunction

   // Returns positioned just after the negedge at which the condition holds.
   task automatic wait_for(input int sel, input string tag);
      int n = 0;
      at_neg();
      while (cond(sel) !== 1'b1 && n < 300) begin
         at_pos();
         at_neg();
         n++;
      end
      check({tag, " reached"}, cond(sel), 1'b1);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      cpu_req_i = 1'b0;
      at_neg();
      at_pos();
      rst_i = 1'b0;
      hits_exp = 0;
      misses_exp = 0;
   endtask

   task automatic idle_check(input string tag);
      cpu_req_i = 1'b0;
      at_neg();
      check({tag, " stall"}, cpu_stall_o, 1'b0);
      check({tag, " mem_en"}, mem_enable_o, 1'b0);
      check({tag, " mem_wr"}, mem_write_o, 1'b0);
      check({tag, " sram_en"}, sram_enable_o, 1'b0);
      check({tag, " sram_wr"}, sram_write_o, 1'b0);
      check({tag, " rdata"}, cpu_data_o, 32'h0);
      at_pos();
   endtask

   task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input string tag);
      logic       exp_hit;
      logic [7:0] lsb;
      logic [31:0] slot;
      int n = 0;
      cpu_req_i  = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_data_i = wdata;
      exp_hit = s_tag[addr[8:5]][24] && (s_tag[addr[8:5]][22:0] == addr[31:9]);
      if (exp_hit) hits_exp++; else misses_exp++;
      at_neg();
      check({tag, " first stall"}, cpu_stall_o, !exp_hit);
      while (cpu_stall_o !== 1'b0 && n < 300) begin
         at_pos();
         at_neg();
         n++;
      end
      check({tag, " done"}, cpu_stall_o, 1'b0);
      if (we) begin
         lsb  = {addr[4:2], 5'b0};
         slot = sram_data_o[lsb +: 32];
         check({tag, " wr strobe"}, sram_write_o, 1'b1);
         check({tag, " wr tag"}, sram_tag_o, {2'b11, addr[31:9]});
         check({tag, " wr word"}, slot, wdata);
      end else begin
         check({tag, " rdata"}, cpu_data_o, shadow_get(addr));
      end
      at_pos();
      if (we) shadow[addr >> 2] = wdata;
      cpu_req_i = 1'b0;
   endtask

   initial begin
      logic [255:0] d, exp_line;
      logic [31:0]  a;
      rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
      cpu_addr_i = 32'h0; cpu_data_i = 32'h0;
      mem_data_i = 256'h0; mem_ack_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s_tag[i]  = 25'h0;
         s_data[i] = 256'h0;
      end

      // Reset, then idle cycles.
      do_reset();
      for (int i = 0; i < 3; i++) idle_check("idle");

      // Zero-latency read hit.
      d = line_get(32'h20);
      d[31:0] = 32'hDEADBEEF;
      preload(4'd1, 23'h0, 1'b0, d);
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h20;
      at_neg();
      check("hit stall", cpu_stall_o, 1'b0);
      check("hit rdata", cpu_data_o, 32'hDEADBEEF);
      check("hit mem_en", mem_enable_o, 1'b0);
      check("hit sram_wr", sram_write_o, 1'b0);
      at_pos();
      hits_exp++;
      cpu_req_i = 1'b0;

      // Read miss, clean victim, 10-cycle memory.
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
      preload(4'd2, 23'h77, 1'b0, d);
      mem_lat = 10;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h1040;
      misses_exp++;
      at_neg();
      check("rm idle stall", cpu_stall_o, 1'b1);
      check("rm idle mem_en", mem_enable_o, 1'b0);
      at_pos();
      at_neg();
      check("rm miss stall", cpu_stall_o, 1'b1);
      check("rm miss mem_en", mem_enable_o, 1'b0);
      check("rm miss sram_wr", sram_write_o, 1'b0);
      at_pos();
      wait_for(0, "rm readmiss");
      check("rm addr", mem_addr_o, 32'h1040);
      at_pos();
      wait_for(2, "rm refill");
      check("rm refill tag", sram_tag_o, {2'b10, 23'h8});
      check("rm refill data", sram_data_o, line_get(32'h1040));
      check("rm refill stall", cpu_stall_o, 1'b1);
      at_pos();
      at_neg();
      check("rm replay stall", cpu_stall_o, 1'b0);
      check("rm replay rdata", cpu_data_o, shadow_get(32'h1040));
      at_pos();
      cpu_req_i = 1'b0;

      // Write miss with dirty victim: writeback, refill, then write hit.
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
      preload(4'd3, 23'h5, 1'b1, d);
      mem_lat = 3;
      cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h464; cpu_data_i = 32'hCAFEF00D;
      misses_exp++;
      at_neg();
      check("wm idle stall", cpu_stall_o, 1'b1);
      at_pos();
      wait_for(1, "wm writeback");
      check("wm wb addr", mem_addr_o, 32'hA60);
      check("wm wb data", mem_data_o, d);
      at_pos();
      wait_for(0, "wm readmiss");
      check("wm rm addr", mem_addr_o, 32'h460);
      at_pos();
      wait_for(2, "wm refill");
      check("wm refill tag", sram_tag_o, {2'b10, 23'h2});
      at_pos();
      exp_line = line_get(32'h460);
      exp_line[63:32] = 32'hCAFEF00D;
      at_neg();
      check("wm hit stall", cpu_stall_o, 1'b0);
      check("wm hit sram_wr", sram_write_o, 1'b1);
      check("wm hit tag", sram_tag_o, {2'b11, 23'h2});
      check("wm hit data", sram_data_o, exp_line);
      at_pos();
      shadow[32'h464 >> 2] = 32'hCAFEF00D;
      cpu_req_i = 1'b0;
      check("wm victim in mem", line_get(32'hA60), d);

      // Reset during READMISS; a late ack must be ignored.
      mem_auto = 1'b0;
      mem_ack_i = 1'b0;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0020_00A0;
      at_neg();
      at_pos();
      wait_for(0, "rst readmiss");
      at_pos();
      rst_i = 1'b1;
      cpu_req_i = 1'b0;
      at_neg();
      at_pos();
      rst_i = 1'b0;
      hits_exp = 0;
      misses_exp = 0;
      mem_ack_i = 1'b1;
      mem_data_i = {8{32'h1234_5678}};
      at_neg();
      check("rst stall", cpu_stall_o, 1'b0);
      check("rst mem_en", mem_enable_o, 1'b0);
      check("rst sram_wr", sram_write_o, 1'b0);
      at_pos();
      mem_ack_i = 1'b0;
      at_neg();
      check("rst late sram_wr", sram_write_o, 1'b0);
      check("rst late mem_en", mem_enable_o, 1'b0);
      check("rst late stall", cpu_stall_o, 1'b0);
      check("rst set untouched", s_tag[5], 25'h0);
      at_pos();
      mem_auto = 1'b1;
      mem_cnt = 0;

      // Three hits and one miss since reset.
      access(32'h20, 1'b0, 32'h0, "cnt hit0");
      access(32'h24, 1'b0, 32'h0, "cnt hit1");
      access(32'h28, 1'b1, 32'h0BAD_F00D, "cnt hit2");
      access(32'h4020, 1'b0, 32'h0, "cnt miss");
`ifdef DCACHE_CTRL_PERF_EN
      at_neg();
      check("hit_cnt 3", hit_cnt_o, 32'd3);
      check("miss_cnt 1", miss_cnt_o, 32'd1);
      at_pos();
`endif

      // Random traffic over a small address pool to force conflicts.
      for (int i = 0; i < 200; i++) begin
         mem_lat = $urandom_range(1, 6);
         if ($urandom_range(0, 3) == 0) idle_check("rnd idle");
         a = {21'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), 2'b00};
         access(a, 1'($urandom_range(0, 1)), $urandom(), "rnd");
      end

`ifdef DCACHE_CTRL_PERF_EN
      at_neg();
      check("hit_cnt total", hit_cnt_o, hits_exp);
      check("miss_cnt total", miss_cnt_o, misses_exp);
      at_pos();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset; synchronous, active-high.
REQ-003 SHALL have CPU ports: cpu_req_i in 1, cpu_we_i in 1, cpu_addr_i in 32, cpu_data_i in 32 (write word), cpu_data_o out 32 (read word), cpu_stall_o out 1.
REQ-004 SHALL have SRAM ports: sram_addr_o out 4 (set index), sram_tag_o out 25 ([24] valid, [23] dirty, [22:0] tag), sram_data_o out 256, sram_enable_o out 1, sram_write_o out 1, sram_tag_i in 25, sram_data_i in 256, sram_hit_i in 1.
REQ-005 SHALL have memory ports: mem_enable_o out 1, mem_write_o out 1, mem_addr_o out 32, mem_data_o out 256, mem_data_i in 256, mem_ack_i in 1 (one-cycle completion pulse).

Function
REQ-006 SHALL split cpu_addr_i as tag [31:9], index [8:5], word [4:2], byte [1:0] ignored; sram_addr_o = cpu_addr_i[8:5] always.
REQ-007 SHALL implement FSM states IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
REQ-008 IDLE: cpu_req_i & sram_hit_i -> stay IDLE, cpu_stall_o=0 same cycle (zero-latency hit); cpu_req_i & ~sram_hit_i -> MISS, cpu_stall_o=1.
REQ-009 Read hit: cpu_data_o = sram_data_i[32*word +: 32], combinational.
REQ-010 Write hit: same cycle sram_enable_o=1, sram_write_o=1, sram_data_o = sram_data_i with word slot replaced by cpu_data_i, sram_tag_o = {1,1,tag}.
REQ-011 MISS: victim presented on sram_tag_i/sram_data_i; victim valid & dirty -> WRITEBACK, else -> READMISS.
REQ-012 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim_tag[22:0], index, 5'b0}, mem_data_o = victim data latched on MISS exit; held until mem_ack_i, then -> READMISS.
REQ-013 READMISS: mem_enable_o=1, mem_write_o=0, mem_addr_o = {cpu_addr_i[31:5], 5'b0}; on mem_ack_i latch mem_data_i, -> READMISSOK.
REQ-014 READMISSOK: one cycle, sram_enable_o=1, sram_write_o=1, sram_data_o = latched line, sram_tag_o = {1,0,tag}; -> IDLE, where the request is replayed and hits.
REQ-015 cpu_stall_o SHALL be 1 in every state except IDLE; in IDLE equals cpu_req_i & ~sram_hit_i.
REQ-016 mem_ack_i outside WRITEBACK/READMISS SHALL be ignored; mem_enable_o/sram_write_o SHALL be 0 in states not listed above.
REQ-017 cpu_addr_i, cpu_we_i, cpu_data_i SHALL be held stable by the CPU while cpu_stall_o=1; controller does not re-latch them.
REQ-018 cpu_req_i=0 in IDLE -> no SRAM write, no memory access, stall 0.

Reset
REQ-019 rst_i=1 at a clock edge SHALL force IDLE and clear latched victim/refill registers, regardless of current state, including mid-WRITEBACK/READMISS.
REQ-020 After reset: cpu_stall_o=0 (with cpu_req_i=0), mem_enable_o=0, mem_write_o=0, sram_enable_o=0, sram_write_o=0, cpu_data_o=0 when no hit.
REQ-021 A mem_ack_i arriving after reset for an aborted transaction SHALL be ignored.

Configuration
REQ-022 Macro DCACHE_CTRL_PERF_EN defined: add outputs hit_cnt_o[31:0], miss_cnt_o[31:0]; hit_cnt increments once per IDLE hit cycle with cpu_req_i=1 excluding the replay after refill; miss_cnt increments on each IDLE->MISS; both wrap at 2^32, cleared by rst_i.
REQ-023 Macro undefined: counters and ports absent; all other behaviour identical.

Verification
REQ-024 Reset, cpu_req_i=0 for 3 cycles -> all enables 0, cpu_stall_o=0.
REQ-025 Read 0x00000020 with sram_hit_i=1, word 0 = 0xDEADBEEF -> cpu_data_o=0xDEADBEEF, stall 0, no mem access.
REQ-026 Read miss 0x00001040, victim clean -> MISS, READMISS with mem_addr_o=0x00001040, ack after 10 cycles, READMISSOK writes tag {1,0,23'h8}, stall drops next IDLE hit.
REQ-027 Write miss 0x00000464, victim tag {1,1,23'h5} -> WRITEBACK mem_addr_o=0x00000A60 mem_write_o=1, then READMISS 0x00000460, then write hit sets dirty bit, word 1 replaced.
REQ-028 rst_i during READMISS, then mem_ack_i next cycle -> IDLE, no SRAM write.
REQ-029 With DCACHE_CTRL_PERF_EN: 3 hits + 1 miss -> hit_cnt_o=3 (replay excluded), miss_cnt_o=1.
